arrow_launcher: RTL and testbench

Game sequencer that drives the `arrow` block's input interface and consumes its hit outputs. It does the following:
- Spawns one arrow at a time with pseudo-random direction, per-level speed and an optional inversed trajectory.
- Holds the arrow valid for the whole flight.
- Retires the arrow on its hit pulse and scores the outcome (blocked vs. player hit).
- Ends the game when lives reach zero.

It sits between the game-control/top level and `arrow`, in the pixel-clock domain.

---
 rtl/arrow_pkg.sv | 23 ++
 rtl/arrow_launcher_lfsr16.sv | 20 ++
 rtl/arrow_launcher.sv | 185 ++++++++++++++++++
 tb/tb_arrow_launcher.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared launcher state encoding, arrow direction codes and LFSR helpers.
package arrow_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    FLIGHT = 2'd2,
    DONE   = 2'd3
  } launcher_state_e;

  localparam logic [1:0] DIR_TOP    = 2'd0;
  localparam logic [1:0] DIR_BOTTOM = 2'd1;
  localparam logic [1:0] DIR_RIGHT  = 2'd2;
  localparam logic [1:0] DIR_LEFT   = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One Galois step: shift right, fold the mask back in when a 1 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/arrow_launcher_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high; reset loads SEED.
module lfsr16
  import arrow_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEED;
    else if (step)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/arrow_launcher.sv
// Arrow game sequencer: spawns one arrow at a time, scores hits, tracks lives/levels.
// Define ARROW_INVERSE_EN to allow inversed arrows from level INV_LEVEL upward.
module arrow_launcher
  import arrow_pkg::*;
#(
  parameter int          NUM_LIVES      = 3,
  parameter int          GAP_FRAMES     = 30,
  parameter int          TIMEOUT_FRAMES = 255,
  parameter int          MIN_SPEED      = 1,
  parameter int          MAX_SPEED      = 7,
  parameter int          LEVEL_UP_HITS  = 8,
  parameter int          INV_LEVEL      = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        is_hit_in,
  input  logic        hit_player_in,
  output logic        valid_out,
  output logic [2:0]  speed_out,
  output logic [1:0]  direction_out,
  output logic        inversed_out,
  output logic        next_out,
  output logic [15:0] score_out,
  output logic [3:0]  lives_out,
  output logic [3:0]  level_out,
  output logic        game_over_out
);

  localparam logic [1:0]  S_IDLE   = IDLE;
  localparam logic [1:0]  S_GAP    = GAP;
  localparam logic [1:0]  S_FLIGHT = FLIGHT;
  localparam logic [1:0]  S_DONE   = DONE;
  localparam logic [15:0] GAP_LD   = 16'(GAP_FRAMES);
  localparam logic [15:0] TMO_LD   = 16'(TIMEOUT_FRAMES);
  localparam logic [3:0]  LIVES_LD = 4'(NUM_LIVES);
  localparam logic [7:0]  BLK_LAST = 8'(LEVEL_UP_HITS - 1);

  logic [1:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  blk_cnt;
  logic [1:0]  q_dir;
  logic [15:0] lfsr;
  logic        frame_tick;
  logic        retire;
  logic        player_hit;
  logic [15:0] score_nx;
  logic [3:0]  level_nx;
  logic [3:0]  lives_nx;
  logic [7:0]  blk_nx;
  logic [3:0]  entry_level;
  logic        q_inv_nx;
  logic [4:0]  speed_raw;
  logic [2:0]  speed_nx;
  logic        lfsr_unused;

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (frame_tick),
    .state (lfsr)
  );

  // A hit on the same tick as timeout expiry is one retire, scored by the hit.
  always_comb begin
    retire     = 1'b0;
    player_hit = 1'b0;
    if (state == S_FLIGHT) begin
      if (is_hit_in) begin
        retire     = 1'b1;
        player_hit = hit_player_in;
      end else if (frame_tick && frame_cnt == 16'd1) begin
        retire     = 1'b1;
        player_hit = 1'b1;
      end
    end
  end

  always_comb begin
    score_nx = score_out;
    level_nx = level_out;
    blk_nx   = blk_cnt;
    if (retire && !player_hit) begin
      if (score_out != 16'hFFFF)
        score_nx = score_out + 16'd1;
      if (blk_cnt == BLK_LAST) begin
        blk_nx = 8'd0;
        if (level_out != 4'd15)
          level_nx = level_out + 4'd1;
      end else begin
        blk_nx = blk_cnt + 8'd1;
      end
    end
  end

  assign lives_nx    = (retire && player_hit) ? lives_out - 4'd1 : lives_out;
  assign entry_level = (state == S_FLIGHT) ? level_nx : 4'd0;
  assign speed_raw   = 5'(MIN_SPEED) + {1'b0, level_out};
  assign speed_nx    = (speed_raw > 5'(MAX_SPEED)) ? 3'(MAX_SPEED) : speed_raw[2:0];

`ifdef ARROW_INVERSE_EN
  assign q_inv_nx    = lfsr[2] && ({28'd0, entry_level} >= INV_LEVEL);
  assign lfsr_unused = ^lfsr[15:3];
`else
  assign q_inv_nx    = 1'b0;
  assign lfsr_unused = ^{lfsr[15:2], entry_level, INV_LEVEL[0]};
`endif

  // next_out doubles as the queued arrow's inversed flag until launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      frame_cnt     <= 16'd0;
      blk_cnt       <= 8'd0;
      q_dir         <= 2'd0;
      valid_out     <= 1'b0;
      speed_out     <= 3'd0;
      direction_out <= 2'd0;
      inversed_out  <= 1'b0;
      next_out      <= 1'b0;
      score_out     <= 16'd0;
      lives_out     <= LIVES_LD;
      level_out     <= 4'd0;
      game_over_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            state         <= S_GAP;
            frame_cnt     <= GAP_LD;
            q_dir         <= lfsr[1:0];
            next_out      <= q_inv_nx;
            score_out     <= 16'd0;
            level_out     <= 4'd0;
            blk_cnt       <= 8'd0;
            lives_out     <= LIVES_LD;
            game_over_out <= 1'b0;
          end
        end
        S_GAP: begin
          if (frame_tick) begin
            if (frame_cnt == 16'd1) begin
              state         <= S_FLIGHT;
              frame_cnt     <= TMO_LD;
              valid_out     <= 1'b1;
              direction_out <= q_dir;
              inversed_out  <= next_out;
              speed_out     <= speed_nx;
              next_out      <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt - 16'd1;
            end
          end
        end
        S_FLIGHT: begin
          if (retire) begin
            valid_out <= 1'b0;
            score_out <= score_nx;
            level_out <= level_nx;
            blk_cnt   <= blk_nx;
            lives_out <= lives_nx;
            if (lives_nx == 4'd0) begin
              state         <= S_DONE;
              game_over_out <= 1'b1;
            end else begin
              state     <= S_GAP;
              frame_cnt <= GAP_LD;
              q_dir     <= lfsr[1:0];
              next_out  <= q_inv_nx;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_launcher.sv
// Randomized scoreboard bench for arrow_launcher; follows ARROW_INVERSE_EN like the design.
`timescale 1ns/1ps
module tb_arrow_launcher;

  localparam int NL = 3, GF = 2, TF = 4, MINS = 1, MAXS = 7, LUH = 8, INVL = 2;
`ifdef ARROW_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        start_in = 1'b0, is_hit_in = 1'b0, hit_player_in = 1'b0;
  logic        valid_out, inversed_out, next_out, game_over_out;
  logic [2:0]  speed_out;
  logic [1:0]  direction_out;
  logic [15:0] score_out;
  logic [3:0]  lives_out, level_out;

  always #5 clk = ~clk;

  arrow_launcher #(
    .NUM_LIVES(NL), .GAP_FRAMES(GF), .TIMEOUT_FRAMES(TF), .MIN_SPEED(MINS),
    .MAX_SPEED(MAXS), .LEVEL_UP_HITS(LUH), .INV_LEVEL(INVL), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .start_in(start_in), .is_hit_in(is_hit_in), .hit_player_in(hit_player_in),
    .valid_out(valid_out), .speed_out(speed_out), .direction_out(direction_out),
    .inversed_out(inversed_out), .next_out(next_out), .score_out(score_out),
    .lives_out(lives_out), .level_out(level_out), .game_over_out(game_over_out)
  );

  int passed = 0, total = 0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Game-level reference model.
  typedef enum {P_WAIT, P_PAUSE, P_AIR, P_OVER} phase_t;
  typedef struct { bit launch; int f0; int f1; int f2; int f3; } ev_t;

  ev_t    evq[$];
  phase_t m_phase;
  int     m_left, m_lfsr, m_score, m_lives, m_level, m_blocks, m_qdir;
  bit     m_qinv, m_gap_new;
  int     cyc = 0;
  bit     inv_seen = 0, next_seen = 0;

  function automatic void model_reset();
    m_phase = P_WAIT; m_left = 0; m_lfsr = 'hACE1; m_score = 0; m_lives = NL;
    m_level = 0; m_blocks = 0; m_qdir = 0; m_qinv = 0; m_gap_new = 0;
  endfunction

  function automatic void draw(int l);
    m_phase   = P_PAUSE;
    m_left    = GF;
    m_qdir    = l % 4;
    m_qinv    = INV_EN && ((l / 4) % 2 == 1) && (m_level >= INVL);
    m_gap_new = 1;
  endfunction

  function automatic void model_step(bit st, bit hit, bit hp, bit tick);
    int lpre;
    bit ret, pl;
    lpre = m_lfsr; ret = 0; pl = 0;
    case (m_phase)
      P_WAIT, P_OVER: begin
        if (st) begin
          m_score = 0; m_level = 0; m_blocks = 0; m_lives = NL;
          draw(lpre);
        end
      end
      P_PAUSE: begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = P_AIR;
            m_left  = TF;
            evq.push_back('{1'b1, m_qdir, (MINS + m_level > MAXS) ? MAXS : MINS + m_level, int'(m_qinv), 0});
          end
        end
      end
      P_AIR: begin
        if (hit) begin
          ret = 1; pl = hp;
        end else if (tick) begin
          m_left--;
          if (m_left == 0) begin ret = 1; pl = 1; end
        end
        if (ret) begin
          if (pl) m_lives--;
          else begin
            if (m_score < 65535) m_score++;
            m_blocks++;
            if (m_blocks % LUH == 0 && m_level < 15) m_level++;
          end
          evq.push_back('{1'b0, m_score, m_lives, m_level, int'(m_lives == 0)});
          if (m_lives == 0) m_phase = P_OVER;
          else draw(lpre);
        end
      end
      default: ;
    endcase
    if (tick) m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
  endfunction

  function automatic bit tick_at(int c);
    return (c % 5 == 0) && ((c / 5) % 2 == 0);
  endfunction

  task automatic cycle(input bit st, input bit hit, input bit hp);
    bit tick;
    start_in = st; is_hit_in = hit; hit_player_in = hp;
    hcount_in = 11'(cyc % 5);
    vcount_in = 10'((cyc / 5) % 2);
    tick = tick_at(cyc);
    cyc++;
    @(posedge clk);
    model_step(st, hit, hp, tick);
    #1;
    if (next_out) next_seen = 1;
    if (m_gap_new && m_phase == P_PAUSE) begin
      m_gap_new = 0;
      check("next_out_queued", next_out, m_qinv);
    end
  endtask

  task automatic wait_flight();
    int n;
    n = 0;
    while (m_phase == P_PAUSE && n < 200) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      n++;
    end
    if (m_phase == P_PAUSE) check("wait_flight_bound", 0, 1);
  endtask

  // mode 0 timeout, 1 player hit, 2 block after delay, 3 block when lfsr[2] set, 4 block on expiry tick
  task automatic fly(input int mode, input int delay);
    int n;
    bit hit;
    n = 0;
    while (m_phase == P_AIR && n < 400) begin
      case (mode)
        1, 2:    hit = (n >= delay);
        3:       hit = ((m_lfsr / 4) % 2 == 1) || (m_left == 1 && tick_at(cyc));
        4:       hit = (m_left == 1 && tick_at(cyc));
        default: hit = 0;
      endcase
      if (hit) cycle(1'b0, 1'b1, mode == 1);
      else cycle($urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 1) == 1);
      n++;
    end
    if (m_phase == P_AIR) check("flight_bound", 0, 1);
  endtask

  // Monitor: pops the scoreboard on every valid_out edge.
  logic       prev_v = 0;
  bit         seen_fall = 0;
  int         gap_ticks = 0;
  ev_t        mon_e;
  logic [1:0] f_dir;
  logic [2:0] f_spd;
  logic       f_inv;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0; seen_fall = 0; gap_ticks = 0;
    end else begin
      if (!prev_v && valid_out) begin
        if (evq.size() == 0) check("launch_expected", 0, 1);
        else begin
          mon_e = evq.pop_front();
          check("launch_kind", int'(mon_e.launch), 1);
          check("launch_direction", direction_out, mon_e.f0);
          check("launch_speed", speed_out, mon_e.f1);
          check("launch_inversed", inversed_out, mon_e.f2);
        end
        check("launch_timing", int'(m_phase == P_AIR), 1);
        if (seen_fall) check("gap_frames_low", int'(gap_ticks >= GF), 1);
        f_dir = direction_out; f_spd = speed_out; f_inv = inversed_out;
        if (inversed_out) inv_seen = 1;
      end else if (prev_v && valid_out) begin
        check("flight_stable", int'({direction_out, speed_out, inversed_out} == {f_dir, f_spd, f_inv}), 1);
      end else if (prev_v && !valid_out) begin
        if (evq.size() == 0) check("retire_expected", 0, 1);
        else begin
          mon_e = evq.pop_front();
          check("retire_kind", int'(mon_e.launch), 0);
          check("retire_score", score_out, mon_e.f0);
          check("retire_lives", lives_out, mon_e.f1);
          check("retire_level", level_out, mon_e.f2);
          check("retire_game_over", game_over_out, mon_e.f3);
        end
        check("retire_timing", int'(m_phase != P_AIR), 1);
        seen_fall = 1; gap_ticks = 0;
      end
      if (!valid_out && hcount_in == 11'd0 && vcount_in == 10'd0) gap_ticks++;
      prev_v = valid_out;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #3;
    check("reset_valid", valid_out, 0);
    check("reset_lives", lives_out, NL);
    check("reset_score", score_out, 0);
    check("reset_level", level_out, 0);
    check("reset_game_over", game_over_out, 0);
    check("reset_speed", speed_out, 0);
    check("reset_direction", direction_out, 0);
    check("reset_inversed", inversed_out, 0);
    check("reset_next", next_out, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    repeat (4) cycle(1'b0, 1'b1, $urandom_range(0, 1) == 1);
    check("idle_hit_valid", valid_out, 0);
    check("idle_hit_lives", lives_out, NL);
    cycle(1'b1, 1'b0, 1'b0);

    // Blocked arrows: level climbs, then steer draws toward inversed arrows.
    for (int a = 0; a < 40; a++) begin
      wait_flight();
      if (m_level >= INVL) fly(3, 0);
      else if (a % 4 == 3) fly(4, 0);
      else fly(2, $urandom_range(0, 25));
      if (a == 7) begin
        check("score_after_8", score_out, 8);
        check("level_after_8", level_out, 1);
      end
      if (a >= 19 && (inv_seen || !INV_EN)) break;
    end
`ifdef ARROW_INVERSE_EN
    check("inverse_arrow_seen", int'(inv_seen), 1);
`else
    check("inverse_never", int'(inv_seen || next_seen), 0);
`endif

    // Mixed outcomes until the game ends.
    for (int a = 0; a < 200 && m_phase != P_OVER; a++) begin
      wait_flight();
      case ($urandom_range(0, 3))
        0:       fly(0, 0);
        1:       fly(1, $urandom_range(0, 30));
        default: fly(2, $urandom_range(0, 45));
      endcase
    end
    check("game_over_out", game_over_out, 1);
    check("game_over_lives", lives_out, 0);
    repeat (6) cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    check("done_valid_low", valid_out, 0);
    check("done_game_over", game_over_out, 1);
    check("done_score_hold", score_out, m_score);
    check("done_level_hold", level_out, m_level);

    cycle(1'b1, 1'b0, 1'b0);
    check("restart_lives", lives_out, NL);
    check("restart_score", score_out, 0);
    check("restart_level", level_out, 0);
    check("restart_game_over", game_over_out, 0);

    // Reset in the middle of a flight after a scored block.
    wait_flight();
    fly(2, 3);
    wait_flight();
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", valid_out, 0);
    check("async_rst_score", score_out, 0);
    check("async_rst_lives", lives_out, NL);
    check("async_rst_game_over", game_over_out, 0);
    model_reset();
    evq.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    repeat (6) cycle(1'b0, 1'b1, $urandom_range(0, 1) == 1);
    check("idle_after_rst_valid", valid_out, 0);
    check("idle_after_rst_score", score_out, 0);
    check("idle_after_rst_lives", lives_out, NL);
    check("queue_drained", evq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
